// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state type and default datapath width
package cpu_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/subtractor.sv
// subtractor: WIDTH-bit a-b with borrow-out
module subtractor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring sequential divider, one quotient bit per cycle; SEQ_DIVIDER_SIGNED_EN adds signed mode
module seq_divider
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] input_dividend,
  input  logic [WIDTH-1:0] input_divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] output_quotient,
  output logic [WIDTH-1:0] output_remainder,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nxt;
  logic [WIDTH-1:0] rem, dvd, dsr, rem_sh, diff, rem_n, dvd_n, mag_a, mag_b;
  logic [CW-1:0] cnt;
  logic borrow, take, last, sa, sb, neg_q, neg_r, accept, zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
  assign sa = is_signed & input_dividend[WIDTH-1];
  assign sb = is_signed & input_divisor[WIDTH-1];
`else
  assign sa = 1'b0;
  assign sb = 1'b0;
`endif
  assign mag_a = sa ? -input_dividend : input_dividend;
  assign mag_b = sb ? -input_divisor : input_divisor;
  assign accept = state == IDLE && start;
  assign zero = input_divisor == '0;
  assign last = cnt == CW'(WIDTH - 1);
  // partial remainder needs WIDTH+1 bits after the shift; the dropped MSB forces a take
  assign rem_sh = {rem[WIDTH-2:0], dvd[WIDTH-1]};
  subtractor #(.WIDTH(WIDTH)) u_sub (.a(rem_sh), .b(dsr), .diff(diff), .borrow(borrow));
  assign take = rem[WIDTH-1] | ~borrow;
  assign rem_n = take ? diff : rem_sh;
  assign dvd_n = {dvd[WIDTH-2:0], take};
  always_comb begin
    state_nxt = state == IDLE ? (start ? (zero ? DONE : RUN) : IDLE)
              : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      dvd <= '0;
      dsr <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      output_quotient <= '0;
      output_remainder <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rem <= '0;
        dvd <= mag_a;
        dsr <= mag_b;
        cnt <= '0;
        neg_q <= sa ^ sb;
        neg_r <= sa;
        if (zero) begin
          output_quotient <= '1;
          output_remainder <= input_dividend;
          div_zero <= 1'b1;
        end
      end else if (state == RUN) begin
        rem <= rem_n;
        dvd <= dvd_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          output_quotient <= neg_q ? -dvd_n : dvd_n;
          output_remainder <= neg_r ? -rem_n : rem_n;
          div_zero <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider (signed cases under SEQ_DIVIDER_SIGNED_EN)
module tb_seq_divider;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, is_sg = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic busy, done, div_zero;
  logic [31:0] quotient, remainder;
  int vectors = 0, miscompares = 0, n;

  seq_divider dut (
    .clk(clk), .rst(rst), .start(start),
    .input_dividend(dividend), .input_divisor(divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .is_signed(is_sg),
`endif
    .busy(busy), .done(done),
    .output_quotient(quotient), .output_remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic s);
    start = 1'b1;
    dividend = a;
    divisor = b;
    is_sg = s;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic result(input string tag, input int lat, input logic [31:0] q, input logic [31:0] r, input logic dz);
    wait_done(n);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_q"}, quotient, q);
    chk({tag, "_r"}, remainder, r);
    chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, dz});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    go(32'd100, 32'd7, 1'b0);
    chk("run_busy", {31'd0, busy}, 32'd1);
    result("basic", 33, 32'd14, 32'd2, 1'b0);
    @(posedge clk);
    #1 chk("done_pulse", {31'd0, done}, 32'd0);
    go(32'd5, 32'd0, 1'b0);
    result("zero", 1, 32'hFFFF_FFFF, 32'd5, 1'b1);
    @(posedge clk);
    #1 go(32'hFFFF_FFFF, 32'd1, 1'b0);
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    dividend = 32'd9;
    divisor = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    n = 11;
    while (!done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("busy_start_lat", n, 33);
    chk("busy_start_q", quotient, 32'hFFFF_FFFF);
    chk("busy_start_r", remainder, 32'd0);
    @(posedge clk);
    #1 go(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    result("bigdiv", 33, 32'd1, 32'h7FFF_FFFE, 1'b0);
    @(posedge clk);
    #1 go(32'd1000, 32'd3, 1'b0);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_q", quotient, 32'd0);
    chk("midrst_r", remainder, 32'd0);
    chk("midrst_dz", {31'd0, div_zero}, 32'd0);
    @(posedge clk);
    #1 chk("midrst_idle", {31'd0, busy}, 32'd0);
    go(32'd1000, 32'd3, 1'b0);
    result("after_rst", 33, 32'd333, 32'd1, 1'b0);
    start = 1'b1;
    dividend = 32'd0;
    divisor = 32'd5;
    @(posedge clk);
    #1 go(32'd0, 32'd5, 1'b0);
    result("b2b", 33, 32'd0, 32'd0, 1'b0);
`ifdef SEQ_DIVIDER_SIGNED_EN
    @(posedge clk);
    #1 go(32'hFFFF_FFF9, 32'd2, 1'b1);
    result("s_neg7_2", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk);
    #1 go(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    result("s_min_m1", 33, 32'h8000_0000, 32'd0, 1'b0);
    @(posedge clk);
    #1 go(32'hFFFF_FFF9, 32'd0, 1'b1);
    result("s_zero", 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock (all state updates on the rising edge).
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a division, sampled only in IDLE.
REQ-005 SHALL have port input_dividend, input, WIDTH, the dividend, captured on the accepted start edge.
REQ-006 SHALL have port input_divisor, input, WIDTH, the divisor, captured on the accepted start edge.
REQ-007 SHALL have port busy, output, 1, high while a division is in progress (RUN state).
REQ-008 SHALL have port done, output, 1, a one-cycle pulse when the results are valid.
REQ-009 SHALL have port output_quotient, output, WIDTH, the quotient, held until the next accepted start.
REQ-010 SHALL have port output_remainder, output, WIDTH, the remainder, held until the next accepted start.
REQ-011 SHALL have port div_zero, output, 1, set with done when the divisor was zero; held with the results.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
- IDLE->RUN on start with a nonzero divisor.
- IDLE->DONE on start with a zero divisor.
- RUN->DONE after WIDTH iterations.
- DONE->IDLE unconditionally.
REQ-013 SHALL perform restoring division, one quotient bit per RUN cycle, MSB first: shift {rem,dvd} left 1, trial-subtract divisor from rem, keep the difference and set the quotient bit iff no borrow.
REQ-014 SHALL assert done exactly WIDTH+1 cycles after the accepted start edge for a nonzero divisor, and 1 cycle after it for a zero divisor.
REQ-015 SHALL, on a zero divisor, produce quotient all-ones, remainder = dividend, and div_zero=1.
REQ-016 SHALL ignore start while in RUN or DONE, with no effect on the result or the timing.
REQ-017 SHALL keep done high for exactly one cycle; busy and done are never high together.
REQ-018 SHALL leave results unsigned and exact: dividend = quotient*divisor + remainder, with remainder < divisor.

Reset
REQ-019 SHALL, on rst, enter IDLE, clear busy, done, div_zero, output_quotient, output_remainder and the iteration counter on that edge, including mid-RUN; a start sampled in the same cycle as rst is discarded.

Configuration
REQ-020 SHALL, with SEQ_DIVIDER_SIGNED_EN defined, add input port is_signed (1 bit, captured at start).
- Operands are converted to magnitudes before RUN; signs are fixed up in the DONE transition, with no extra cycles.
- Quotient truncates toward zero; the remainder takes the sign of the dividend.
- Signed zero divisor: quotient all-ones, remainder = dividend.
- MIN/-1: quotient = MIN, remainder = 0.
REQ-021 SHALL, without SEQ_DIVIDER_SIGNED_EN, omit is_signed and operate unsigned only.

Structure
REQ-022 SHALL place the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH constant in shared package cpu_pkg.
REQ-023 SHALL implement the trial subtraction in one sub-module, subtractor (WIDTH-bit a-b with borrow-out), reusable by the ALU.

Verification
REQ-024 SHALL cover the basic case: 100/7 unsigned -> done 33 cycles after start, quotient 14, remainder 2, div_zero 0.
REQ-025 SHALL cover a zero divisor: 5/0 -> done 1 cycle after start, quotient 0xFFFFFFFF, remainder 5, div_zero 1.
REQ-026 SHALL cover start while busy: 0xFFFFFFFF/1 started, then start with 9/3 at cycle 10 -> ignored; quotient 0xFFFFFFFF, remainder 0 at cycle 33.
REQ-027 SHALL cover reset mid-operation: rst at cycle 15 of 1000/3 -> next cycle busy 0, done 0, outputs 0; a new 1000/3 then gives 333 r 1.
REQ-028 SHALL cover signed division (SEQ_DIVIDER_SIGNED_EN): -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 0x80000000/-1 -> quotient 0x80000000, remainder 0.
REQ-029 SHALL cover back-to-back operation: start reasserted the cycle after done -> accepted; 0/5 gives quotient 0, remainder 0, div_zero 0.
